// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response encodings shared by soc910 bus blocks
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/soc910_pkg.sv
// rtl/soc910_pkg.sv - soc910 AXI-Lite and APB bus struct types and constants
package soc910_pkg;

  localparam int unsigned AxiAddrWidth = 40;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  // ACCESS cycles an APB slave may stall before the bridge gives up on it
  localparam int unsigned ApbTimeoutCycles = 1024;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [2:0]              prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    axi_pkg::resp_t resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    axi_pkg::resp_t          resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [AxiDataWidth-1:0] pwdata;
    logic [AxiStrbWidth-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                    pready;
    logic [AxiDataWidth-1:0] prdata;
    logic                    pslverr;
  } apb_resp_t;

endpackage

// File: rtl/soc910_axi_lite_to_apb.sv
// rtl/soc910_axi_lite_to_apb.sv - AXI-Lite to APB bridge with fair read/write arbitration and APB timeout
module soc910_axi_lite_to_apb
  import axi_pkg::*;
#(
  parameter type         axi_lite_req_t = soc910_pkg::axi_lite_req_t,
  parameter type         axi_lite_rsp_t = soc910_pkg::axi_lite_resp_t,
  parameter type         apb_req_t      = soc910_pkg::apb_req_t,
  parameter type         apb_rsp_t      = soc910_pkg::apb_resp_t,
  parameter int unsigned TimeoutCycles  = soc910_pkg::ApbTimeoutCycles
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t axi_lite_req_i,
  output axi_lite_rsp_t axi_lite_rsp_o,
  output apb_req_t      apb_req_o,
  input  apb_rsp_t      apb_rsp_i,
  output logic          timeout_o
);

  localparam int AddrW = soc910_pkg::AxiAddrWidth;
  localparam int DataW = soc910_pkg::AxiDataWidth;
  localparam int StrbW = soc910_pkg::AxiStrbWidth;
  // Counter must be able to hold TimeoutCycles itself; keep one bit when disabled
  localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;  // 1: last grant was a write, so a read wins a tie
  logic              is_wr_q, is_wr_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [2:0]        prot_q, prot_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0]  strb_q, strb_d;
  resp_t             resp_q, resp_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              wr_cand, rd_cand;
  logic              grant_wr, grant_rd;

  // Tie-break between a complete write (AW and W together) and a read
  always_comb begin
    wr_cand  = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
    rd_cand  = axi_lite_req_i.ar_valid;
    grant_wr = (state_q == ST_IDLE) && wr_cand && (!rd_cand || !last_wr_q);
    grant_rd = (state_q == ST_IDLE) && rd_cand && (!wr_cand || last_wr_q);
  end

  // Next-state, capture and AXI/APB output logic
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.b.resp   = resp_q;
    axi_lite_rsp_o.r.resp   = resp_q;
    axi_lite_rsp_o.r.data   = rdata_q;
    // Readies are held low while reset is asserted so nothing is accepted then
    axi_lite_rsp_o.aw_ready = rst_ni && grant_wr;
    axi_lite_rsp_o.w_ready  = rst_ni && grant_wr;
    axi_lite_rsp_o.ar_ready = rst_ni && grant_rd;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          addr_d    = axi_lite_req_i.aw.addr;
          prot_d    = axi_lite_req_i.aw.prot;
          wdata_d   = axi_lite_req_i.w.data;
          strb_d    = axi_lite_req_i.w.strb;
          is_wr_d   = 1'b1;
          last_wr_d = 1'b1;
          state_d   = ST_SETUP;
        end else if (grant_rd) begin
          addr_d    = axi_lite_req_i.ar.addr;
          prot_d    = axi_lite_req_i.ar.prot;
          wdata_d   = '0;
          strb_d    = '0;
          is_wr_d   = 1'b0;
          last_wr_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_rsp_i.pready) begin
          // A late pready still beats an expiring counter
          resp_d  = apb_rsp_i.pslverr ? RESP_SLVERR : RESP_OKAY;
          rdata_d = apb_rsp_i.prdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if ((TimeoutCycles != 0) && (cnt_d == CntW'(TimeoutCycles))) begin
            resp_d    = RESP_SLVERR;
            rdata_d   = '0;
            timeout_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (is_wr_q) begin
          axi_lite_rsp_o.b_valid = 1'b1;
          if (axi_lite_req_i.b_ready) state_d = ST_IDLE;
        end else begin
          axi_lite_rsp_o.r_valid = 1'b1;
          if (axi_lite_req_i.r_ready) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    apb_req_o         = '0;
    apb_req_o.paddr   = addr_q;
    apb_req_o.pprot   = prot_q;
    apb_req_o.pwrite  = is_wr_q;
    apb_req_o.pwdata  = wdata_q;
    apb_req_o.pstrb   = strb_q;
    apb_req_o.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    apb_req_o.penable = (state_q == ST_ACCESS);

    timeout_o = timeout_q;
  end

  // State register; reset abandons any APB transfer in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b1;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_soc910_axi_lite_to_apb.sv
// tb/tb_soc910_axi_lite_to_apb.sv - randomized self-checking bench for the AXI-Lite to APB bridge
module tb_soc910_axi_lite_to_apb;
  import soc910_pkg::*;

  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst_ni;
  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  apb_req_t       preq;
  apb_resp_t      prsp;
  logic           timeout;

  always #5 clk = ~clk;

  soc910_axi_lite_to_apb #(.TimeoutCycles(T)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .apb_req_o      (preq),
    .apb_rsp_i      (prsp),
    .timeout_o      (timeout)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit model_last_wr = 1'b1;   // reference arbiter memory: reads win the first tie
  bit last_grant_wr;

  typedef struct {
    bit          offer_wr;
    bit          offer_rd;
    bit          aw_only;
    logic [39:0] waddr;
    logic [39:0] raddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  wprot;
    logic [2:0]  rprot;
    int          waits;
    bit          slverr;
    logic [31:0] rdata;
    int          ready_delay;
  } txn_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input txn_t t);
    bit gw, seen, done, rdy, v;
    int acc, k, lat, stall, extra, stall_ok, psel_n, pen_n, tmo_n, unstable, badv;
    logic [39:0] ea;
    logic [2:0]  ep;
    logic [31:0] ed, edata;
    logic [3:0]  es;
    logic [1:0]  eresp;

    gw    = t.offer_wr && (!t.offer_rd || !model_last_wr);
    acc   = (t.waits < T) ? t.waits + 1 : T;
    eresp = (t.waits >= T || t.slverr) ? 2'b10 : 2'b00;
    edata = (t.waits >= T) ? 32'h0 : t.rdata;
    ea    = gw ? t.waddr : t.raddr;
    ep    = gw ? t.wprot : t.rprot;
    ed    = gw ? t.wdata : 32'h0;
    es    = gw ? t.strb  : 4'h0;

    @(negedge clk);
    req          = '0;
    prsp         = '0;
    req.aw_valid = t.offer_wr || t.aw_only;
    req.w_valid  = t.offer_wr;
    req.ar_valid = t.offer_rd;
    req.aw.addr  = t.waddr;
    req.aw.prot  = t.wprot;
    req.w.data   = t.wdata;
    req.w.strb   = t.strb;
    req.ar.addr  = t.raddr;
    req.ar.prot  = t.rprot;
    #1;
    check("grant", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, gw ? 3'b110 : 3'b001);
    model_last_wr = gw;
    last_grant_wr = gw;

    k = 0; seen = 0; done = 0; lat = -1; stall = 0; extra = 0; stall_ok = 0;
    psel_n = 0; pen_n = 0; tmo_n = 0; unstable = 0; badv = 0;
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
      rdy          = seen && (stall >= ((t.ready_delay > 0) ? t.ready_delay : 1));
      req.aw_valid = seen && !rdy;
      req.w_valid  = seen && !rdy;
      req.ar_valid = seen && !rdy;
      req.b_ready  = rdy;
      req.r_ready  = rdy;
      prsp.pready  = !seen && (k - 2 == t.waits);
      prsp.prdata  = prsp.pready ? t.rdata : $urandom;
      prsp.pslverr = prsp.pready ? t.slverr : 1'($urandom);
      #1;
      psel_n += int'(preq.psel);
      pen_n  += int'(preq.penable);
      tmo_n  += int'(timeout);
      if (preq.psel && (preq.paddr !== ea || preq.pwrite !== gw || preq.pwdata !== ed ||
                        preq.pstrb !== es || preq.pprot !== ep))
        unstable++;
      if (k == 1) begin
        check("setup_psel", {preq.psel, preq.penable}, 2'b10);
        check("paddr", preq.paddr, ea);
        check("pwrite", preq.pwrite, gw);
        check("pwdata", preq.pwdata, ed);
        check("pstrb", preq.pstrb, es);
        check("pprot", preq.pprot, ep);
      end
      v = gw ? rsp.b_valid : rsp.r_valid;
      if (gw ? rsp.r_valid : rsp.b_valid) badv++;
      if (!seen) begin
        if (v) begin
          seen  = 1;
          lat   = k;
          stall = 1;
          if (gw) check("b_resp", rsp.b.resp, eresp);
          else begin
            check("r_resp", rsp.r.resp, eresp);
            check("r_data", rsp.r.data, edata);
          end
        end
      end else if (rdy) begin
        check("hs_valid", v, 1'b1);
        done = 1;
      end else begin
        stall++;
        extra++;
        if (v && !rsp.aw_ready && !rsp.w_ready && !rsp.ar_ready && !preq.psel) stall_ok++;
      end
    end
    check("done", done, 1'b1);
    check("latency", lat, 2 + acc);
    check("psel_cycles", psel_n, 1 + acc);
    check("penable_cycles", pen_n, acc);
    check("timeout_pulses", tmo_n, (t.waits >= T) ? 1 : 0);
    check("apb_stable", unstable, 0);
    check("other_valid", badv, 0);
    if (t.ready_delay > 1) check("stall_hold", stall_ok, extra);

    @(negedge clk);
    req  = '0;
    prsp = '0;
    #1;
    check("valid_drop", {rsp.b_valid, rsp.r_valid}, 2'b00);
  endtask

  function automatic txn_t blank_txn();
    txn_t t;
    t.offer_wr = 0; t.offer_rd = 0; t.aw_only = 0;
    t.waddr = 40'h0; t.raddr = 40'h0; t.wdata = 32'h0; t.strb = 4'h0;
    t.wprot = 3'h0; t.rprot = 3'h0; t.waits = 0; t.slverr = 0;
    t.rdata = 32'h0; t.ready_delay = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int sel;
    t = blank_txn();
    sel = $urandom_range(0, 3);
    t.offer_wr = (sel == 0) || (sel == 2);
    t.offer_rd = (sel != 0);
    t.aw_only  = (sel == 3);
    t.waddr = {8'($urandom), 32'($urandom)};
    t.raddr = {8'($urandom), 32'($urandom)};
    t.wdata = $urandom;
    t.strb  = 4'($urandom);
    t.wprot = 3'($urandom);
    t.rprot = 3'($urandom);
    t.waits = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, 3);
    t.slverr = 1'($urandom);
    t.rdata  = $urandom;
    t.ready_delay = $urandom_range(0, 3);
    return t;
  endfunction

  initial begin
    txn_t t;
    int bad;
    logic [3:0] grants;

    rst_ni = 1'b0;
    req    = '0;
    prsp   = '0;
    req.aw_valid = 1; req.w_valid = 1; req.ar_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_readies", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 3'b000);
    check("rst_valids", {rsp.b_valid, rsp.r_valid}, 2'b00);
    check("rst_apb_ctrl", {preq.psel, preq.penable, preq.pwrite}, 3'b000);
    check("rst_paddr", preq.paddr, 40'h0);
    check("rst_pwdata", {preq.pwdata, preq.pstrb, preq.pprot}, 39'h0);
    check("rst_timeout", timeout, 1'b0);
    req = '0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Simultaneous write and read offers alternate, reads first
    for (int i = 0; i < 4; i++) begin
      t = blank_txn();
      t.offer_wr = 1; t.offer_rd = 1;
      t.waddr = 40'h10_0000_0000 + 40'(i); t.raddr = 40'h20_0000_0000 + 40'(i);
      t.wdata = 32'hC0DE_0000 + i; t.strb = 4'hF; t.rdata = 32'hBEEF_0000 + i;
      do_txn(t);
      grants[i] = last_grant_wr;
    end
    check("arb_sequence", grants, 4'b1010);

    t = blank_txn();
    t.offer_wr = 1; t.waddr = 40'h40_0000_1000; t.wdata = 32'hDEADBEEF; t.strb = 4'hF;
    do_txn(t);

    t = blank_txn();
    t.offer_rd = 1; t.raddr = 40'h40_0000_2000; t.rprot = 3'b010; t.waits = 4; t.rdata = 32'h12345678;
    do_txn(t);

    t = blank_txn();
    t.offer_wr = 1; t.waddr = 40'h40_0000_3000; t.wdata = 32'h0BAD_F00D; t.strb = 4'h3; t.slverr = 1;
    do_txn(t);

    t = blank_txn();
    t.offer_rd = 1; t.raddr = 40'h7F_FFFF_FFFC; t.waits = 100; t.rdata = 32'hFFFF_FFFF;
    do_txn(t);

    t = blank_txn();
    t.offer_wr = 1; t.waddr = 40'h01_2345_6780; t.wdata = 32'h5555_AAAA; t.strb = 4'hC;
    t.waits = 1; t.ready_delay = 5;
    do_txn(t);

    // AW without W cannot win; the pending read goes ahead
    t = blank_txn();
    t.aw_only = 1; t.offer_rd = 1; t.waddr = 40'h0A_0000_0000; t.raddr = 40'h0B_0000_0000;
    t.rdata = 32'h0F0F_0F0F; t.waits = 2;
    do_txn(t);

    // W without AW is never accepted
    @(negedge clk);
    req = '0;
    req.w_valid = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (rsp.aw_ready || rsp.w_ready || rsp.ar_ready || preq.psel) bad++;
    end
    check("lone_w_idle", bad, 0);
    req = '0;

    // Reset during ACCESS abandons the transfer
    @(negedge clk);
    req.ar_valid = 1; req.ar.addr = 40'h33_0000_0040;
    #1;
    check("mid_rst_grant", rsp.ar_ready, 1'b1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #1;
    check("mid_rst_access", {preq.psel, preq.penable}, 2'b11);
    rst_ni = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_apb", {preq.psel, preq.penable}, 2'b00);
    check("mid_rst_paddr", preq.paddr, 40'h0);
    check("mid_rst_valids", {rsp.b_valid, rsp.r_valid}, 2'b00);
    @(negedge clk);
    rst_ni = 1'b1;
    model_last_wr = 1'b1;
    prsp.pready = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (rsp.b_valid || rsp.r_valid || preq.psel) bad++;
    end
    check("post_rst_quiet", bad, 0);
    prsp = '0;

    t = blank_txn();
    t.offer_rd = 1; t.raddr = 40'h33_0000_0080; t.rdata = 32'hA1B2_C3D4; t.waits = 1;
    do_txn(t);

    for (int i = 0; i < 25; i++) do_txn(rand_txn());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
